// File: rtl/temporal_lt_array_pkg.sv
// Shared types and constants for the race-logic less-than array.
package temporal_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        FIRE,
        BLOCKED,
        DONE
    } lt_state_e;

    localparam int GAMMA_CYCLE_WIDTH_DEF = 16;
    localparam int PULSE_WIDTH_DEF       = 8;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int tw_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/temporal_lt_array_if.sv
// Spike bus between column stages, the less-than array and downstream inhibit.
interface temporal_lt_array_if #(
    parameter int N_CH = 8,
    parameter int TW   = 4
);
    logic                      gamma_start;
    logic [N_CH-1:0]           a;
    logic [N_CH-1:0]           b;
    logic [N_CH-1:0]           q;
    logic [N_CH-1:0][TW-1:0]   a_time;
    logic [N_CH-1:0]           lt_flags;
    logic                      gamma_done;

    modport master (
        output gamma_start, a, b,
        input  q, a_time, lt_flags, gamma_done
    );

    modport slave (
        input  gamma_start, a, b,
        output q, a_time, lt_flags, gamma_done
    );
endinterface

// File: rtl/temporal_lt_array_lt_channel.sv
// One a-vs-b race channel: edge detect, arbitration FSM and output pulse timer.
module lt_channel
    import temporal_pkg::*;
#(
    parameter int TW          = 4,
    parameter int PULSE_WIDTH = PULSE_WIDTH_DEF,
    parameter int TIE_PASS    = 0
) (
    input  logic          aclk,
    input  logic          grst,
    input  logic          gamma_start,
    input  logic          window_open,
    input  logic          window_close,
    input  logic [TW-1:0] gcnt,
    input  logic          a,
    input  logic          b,
    output logic          q,
    output logic          win,
    output logic          fired,
    output logic [TW-1:0] a_time
);
    localparam int PCW = tw_of(PULSE_WIDTH);

    lt_state_e      state_q, state_d;
    logic [PCW-1:0] pcnt_q, pcnt_d;
    logic [TW-1:0]  a_time_q, a_time_d;
    logic           fired_q, fired_d;
    logic           prev_a, prev_b;
    logic           a_rise, b_rise;

    assign a_rise = a & ~prev_a;
    assign b_rise = b & ~prev_b;

    always_ff @(posedge aclk or posedge grst) begin
        if (grst) begin
            state_q  <= IDLE;
            pcnt_q   <= '0;
            a_time_q <= '0;
            fired_q  <= 1'b0;
            prev_a   <= 1'b0;
            prev_b   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pcnt_q   <= pcnt_d;
            a_time_q <= a_time_d;
            fired_q  <= fired_d;
            prev_a   <= a;
            prev_b   <= b;
        end
    end

    // gamma_start overrides every state, including edges seen in the same cycle.
    always_comb begin
        state_d  = state_q;
        pcnt_d   = pcnt_q;
        a_time_d = a_time_q;
        fired_d  = fired_q;
        win      = 1'b0;
        if (gamma_start) begin
            state_d  = ARMED;
            pcnt_d   = '0;
            a_time_d = '0;
            fired_d  = 1'b0;
        end else begin
            case (state_q)
                ARMED: begin
                    if (window_open && a_rise && (!b_rise || (TIE_PASS != 0))) begin
                        state_d  = FIRE;
                        win      = 1'b1;
                        fired_d  = 1'b1;
                        a_time_d = gcnt;
                        pcnt_d   = PCW'(PULSE_WIDTH - 1);
                    end else if (window_open && b_rise) begin
                        state_d = BLOCKED;
                    end else if (window_close) begin
                        state_d = DONE;
                    end
                end
                FIRE: begin
                    if (pcnt_q == '0) state_d = DONE;
                    else              pcnt_d  = pcnt_q - 1'b1;
                end
                BLOCKED: begin
                    if (window_close) state_d = DONE;
                end
                default: state_d = state_q;
            endcase
        end
    end

    assign q      = (state_q == FIRE);
    assign fired  = fired_q;
    assign a_time = a_time_q;

endmodule

// File: rtl/temporal_lt_array.sv
// Multi-channel race-logic less-than: shared gamma window, result capture, done strobe.
module temporal_lt_array
    import temporal_pkg::*;
#(
    parameter int N_CH              = 8,
    parameter int GAMMA_CYCLE_WIDTH = GAMMA_CYCLE_WIDTH_DEF,
    parameter int PULSE_WIDTH       = PULSE_WIDTH_DEF,
    parameter int TIE_PASS          = 0
) (
    input  logic                aclk,
    input  logic                grst,
    temporal_lt_array_if.slave  bus
);
    localparam int TW = tw_of(GAMMA_CYCLE_WIDTH);

    logic [TW-1:0]           gcnt;
    logic                    window_open;
    logic                    window_close;
    logic                    gamma_done_q;
    logic [N_CH-1:0]         lt_flags_q;
    logic [N_CH-1:0][TW-1:0] a_time_q;
    logic [N_CH-1:0]         q_w, win_w, fired_w;
    logic [N_CH-1:0][TW-1:0] time_w;

    // A restart in the last open cycle aborts the window, so it never closes normally.
    assign window_close = window_open && (gcnt == TW'(GAMMA_CYCLE_WIDTH - 1)) && !bus.gamma_start;

    always_ff @(posedge aclk or posedge grst) begin
        if (grst) begin
            gcnt        <= '0;
            window_open <= 1'b0;
        end else if (bus.gamma_start) begin
            gcnt        <= '0;
            window_open <= 1'b1;
        end else if (window_close) begin
            window_open <= 1'b0;
        end else if (window_open) begin
            gcnt <= gcnt + 1'b1;
        end
    end

    // Capture includes a channel winning in the very last open cycle.
    always_ff @(posedge aclk or posedge grst) begin
        if (grst) begin
            gamma_done_q <= 1'b0;
            lt_flags_q   <= '0;
            a_time_q     <= '0;
        end else begin
            gamma_done_q <= window_close;
            if (window_close) begin
                for (int i = 0; i < N_CH; i++) begin
                    lt_flags_q[i] <= fired_w[i] | win_w[i];
                    a_time_q[i]   <= win_w[i] ? gcnt : time_w[i];
                end
            end
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        lt_channel #(
            .TW          (TW),
            .PULSE_WIDTH (PULSE_WIDTH),
            .TIE_PASS    (TIE_PASS)
        ) u_ch (
            .aclk         (aclk),
            .grst         (grst),
            .gamma_start  (bus.gamma_start),
            .window_open  (window_open),
            .window_close (window_close),
            .gcnt         (gcnt),
            .a            (bus.a[i]),
            .b            (bus.b[i]),
            .q            (q_w[i]),
            .win          (win_w[i]),
            .fired        (fired_w[i]),
            .a_time       (time_w[i])
        );
    end

    assign bus.q          = q_w;
    assign bus.lt_flags   = lt_flags_q;
    assign bus.a_time     = a_time_q;
    assign bus.gamma_done = gamma_done_q;

endmodule

// File: tb/tb_temporal_lt_array.sv
// Scoreboard bench: two arrays (ties block / ties pass) share one directed spike stream.
module tb_temporal_lt_array;

    localparam int N  = 4;
    localparam int TW = 4;

    typedef struct {
        int dut;
        int ch;
        int start;
        int len;
    } pulse_t;

    typedef struct {
        int          cyc;
        logic [3:0]  flags;
        logic [15:0] times;
    } done_t;

    logic aclk = 1'b0;
    logic grst = 1'b1;
    int   cyc  = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    pulse_t pq[$];
    done_t  dq0[$];
    done_t  dq1[$];

    temporal_lt_array_if #(.N_CH(N), .TW(TW)) bus0 ();
    temporal_lt_array_if #(.N_CH(N), .TW(TW)) bus1 ();

    assign bus1.gamma_start = bus0.gamma_start;
    assign bus1.a           = bus0.a;
    assign bus1.b           = bus0.b;

    temporal_lt_array #(.N_CH(N), .GAMMA_CYCLE_WIDTH(16), .PULSE_WIDTH(8), .TIE_PASS(0)) dut0 (
        .aclk (aclk),
        .grst (grst),
        .bus  (bus0)
    );

    temporal_lt_array #(.N_CH(N), .GAMMA_CYCLE_WIDTH(16), .PULSE_WIDTH(8), .TIE_PASS(1)) dut1 (
        .aclk (aclk),
        .grst (grst),
        .bus  (bus1)
    );

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) begin
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic push_pulse(input int d, input int ch, input int st, input int len);
        pulse_t p;
        p.dut = d; p.ch = ch; p.start = st; p.len = len;
        pq.push_back(p);
    endtask

    task automatic push_done(input int d, input int c, input logic [3:0] f, input logic [15:0] t);
        done_t e;
        e.cyc = c; e.flags = f; e.times = t;
        if (d == 0) dq0.push_back(e);
        else        dq1.push_back(e);
    endtask

    task automatic chk_outs(input string tag, input logic [3:0] q0, input logic [3:0] q1,
                            input logic [3:0] f0, input logic [3:0] f1);
        chk({tag, "_q0"},     32'(bus0.q),        32'(q0));
        chk({tag, "_q1"},     32'(bus1.q),        32'(q1));
        chk({tag, "_flags0"}, 32'(bus0.lt_flags), 32'(f0));
        chk({tag, "_flags1"}, 32'(bus1.lt_flags), 32'(f1));
    endtask

    // Monitor: pops expectations whenever a DUT presents gamma_done or finishes a pulse.
    logic [3:0] prev_q [2];
    int         pstart [2][4];

    initial begin
        prev_q[0] = '0;
        prev_q[1] = '0;
    end

    always @(negedge aclk) begin
        for (int d = 0; d < 2; d++) begin
            logic [3:0]  qv;
            logic        gd;
            logic [3:0]  fl;
            logic [15:0] tm;
            done_t       e;
            int          idx;
            qv = (d == 0) ? bus0.q          : bus1.q;
            gd = (d == 0) ? bus0.gamma_done : bus1.gamma_done;
            fl = (d == 0) ? bus0.lt_flags   : bus1.lt_flags;
            tm = (d == 0) ? bus0.a_time     : bus1.a_time;
            if (gd === 1'b1) begin
                if ((d == 0 && dq0.size() == 0) || (d == 1 && dq1.size() == 0)) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL done_unexpected dut%0d: gamma_done at cyc %0d, required none", d, cyc);
                end else begin
                    if (d == 0) e = dq0.pop_front();
                    else        e = dq1.pop_front();
                    chk($sformatf("done_cyc_dut%0d", d),   32'(cyc), 32'(e.cyc));
                    chk($sformatf("done_flags_dut%0d", d), 32'(fl),  32'(e.flags));
                    chk($sformatf("done_time_dut%0d", d),  32'(tm),  32'(e.times));
                end
            end
            for (int c = 0; c < N; c++) begin
                if (qv[c] === 1'b1 && prev_q[d][c] !== 1'b1) pstart[d][c] = cyc;
                if (qv[c] !== 1'b1 && prev_q[d][c] === 1'b1) begin
                    idx = -1;
                    for (int k = 0; k < pq.size(); k++)
                        if (idx < 0 && pq[k].dut == d && pq[k].ch == c) idx = k;
                    if (idx < 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL pulse_unexpected dut%0d ch%0d: start %0d len %0d, required none",
                                 d, c, pstart[d][c], cyc - pstart[d][c]);
                    end else begin
                        chk($sformatf("pulse_start_dut%0d_ch%0d", d, c), 32'(pstart[d][c]), 32'(pq[idx].start));
                        chk($sformatf("pulse_len_dut%0d_ch%0d", d, c), 32'(cyc - pstart[d][c]), 32'(pq[idx].len));
                        pq.delete(idx);
                    end
                end
            end
            prev_q[d] = qv;
        end
    end

    initial begin
        bus0.gamma_start = 1'b0;
        bus0.a = '0;
        bus0.b = '0;

        wait_cyc(1);
        chk_outs("reset", 4'h0, 4'h0, 4'h0, 4'h0);
        chk("reset_done0", 32'(bus0.gamma_done), 32'd0);
        chk("reset_done1", 32'(bus1.gamma_done), 32'd0);
        chk("reset_time0", 32'(bus0.a_time),     32'd0);
        chk("reset_time1", 32'(bus1.a_time),     32'd0);
        wait_cyc(3);
        grst = 1'b0;

        // Window A: a-wins, b-wins, tie, and an a edge after close.
        push_pulse(0, 0, 9, 8);
        push_pulse(1, 0, 9, 8);
        push_pulse(1, 2, 10, 8);
        push_done(0, 22, 4'b0001, 16'h0002);
        push_done(1, 22, 4'b0101, 16'h0302);
        wait_cyc(5);  bus0.gamma_start = 1'b1;
        wait_cyc(6);  bus0.gamma_start = 1'b0;
        wait_cyc(7);  bus0.b[1] = 1'b1;
        wait_cyc(8);  bus0.a[0] = 1'b1;
        wait_cyc(9);  bus0.a[2] = 1'b1; bus0.b[2] = 1'b1;
        wait_cyc(10); bus0.a[1] = 1'b1;
        wait_cyc(12); bus0.b[0] = 1'b1;
        wait_cyc(22); bus0.a[3] = 1'b1;
        wait_cyc(25); bus0.a = 4'b1000; bus0.b = '0;

        // Window B: restarted while ch0 fires; a[3] stays high and must not trigger.
        push_pulse(0, 0, 32, 6);
        push_pulse(1, 0, 32, 6);
        wait_cyc(28); bus0.gamma_start = 1'b1;
        wait_cyc(29); bus0.gamma_start = 1'b0;
        wait_cyc(31); bus0.a[0] = 1'b1;

        // Window C: b edge coinciding with gamma_start ignored; a win in the last open cycle.
        push_pulse(0, 0, 48, 7);
        push_pulse(1, 0, 48, 7);
        push_pulse(0, 1, 54, 1);
        push_pulse(1, 1, 54, 1);
        push_done(0, 54, 4'b0011, 16'h00F9);
        push_done(1, 54, 4'b0011, 16'h00F9);
        wait_cyc(37); bus0.gamma_start = 1'b1; bus0.b[0] = 1'b1;
        wait_cyc(38); bus0.gamma_start = 1'b0; bus0.b[2] = 1'b1;
        wait_cyc(39); bus0.a[2] = 1'b1;
        wait_cyc(40); bus0.a[0] = 1'b0;
        wait_cyc(47); bus0.a[0] = 1'b1;
        wait_cyc(50);
        chk_outs("hold_after_abort", 4'b0001, 4'b0001, 4'b0001, 4'b0101);
        wait_cyc(53); bus0.a[1] = 1'b1;

        // Window D: gamma_start together with gamma_done.
        push_pulse(0, 3, 60, 8);
        push_pulse(1, 3, 60, 8);
        push_done(0, 71, 4'b1000, 16'h4000);
        push_done(1, 71, 4'b1000, 16'h4000);
        wait_cyc(54); bus0.gamma_start = 1'b1;
        wait_cyc(55); bus0.gamma_start = 1'b0; bus0.a = '0; bus0.b = '0;
        wait_cyc(59); bus0.a[3] = 1'b1;
        wait_cyc(62); bus0.b[2] = 1'b1;
        wait_cyc(72); bus0.a = '0; bus0.b = '0;

        // Window E: reset lands mid-pulse; edges before the next gamma_start are ignored.
        push_pulse(0, 0, 79, 3);
        push_pulse(1, 0, 79, 3);
        wait_cyc(75); bus0.gamma_start = 1'b1;
        wait_cyc(76); bus0.gamma_start = 1'b0;
        wait_cyc(78); bus0.a[0] = 1'b1;
        wait_cyc(82); grst = 1'b1;
        #2;
        chk_outs("async_reset", 4'h0, 4'h0, 4'h0, 4'h0);
        chk("async_reset_done0", 32'(bus0.gamma_done), 32'd0);
        chk("async_reset_done1", 32'(bus1.gamma_done), 32'd0);
        chk("async_reset_time0", 32'(bus0.a_time),     32'd0);
        chk("async_reset_time1", 32'(bus1.a_time),     32'd0);
        wait_cyc(84); grst = 1'b0;
        wait_cyc(86); bus0.a[1] = 1'b1;
        wait_cyc(88); bus0.a = '0; bus0.b = '0;

        // Window F: a edge in the first open cycle.
        push_pulse(0, 2, 92, 8);
        push_pulse(1, 2, 92, 8);
        push_done(0, 107, 4'b0100, 16'h0000);
        push_done(1, 107, 4'b0100, 16'h0000);
        wait_cyc(90); bus0.gamma_start = 1'b1;
        wait_cyc(91); bus0.gamma_start = 1'b0; bus0.a[2] = 1'b1;

        wait_cyc(115);
        foreach (pq[k]) begin
            n_cmp++;
            n_bad++;
            $display("FAIL pulse_missing dut%0d ch%0d: got none, required start %0d len %0d",
                     pq[k].dut, pq[k].ch, pq[k].start, pq[k].len);
        end
        foreach (dq0[k]) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_missing dut0: got none, required gamma_done at cyc %0d", dq0[k].cyc);
        end
        foreach (dq1[k]) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_missing dut1: got none, required gamma_done at cyc %0d", dq1[k].cyc);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
